// File: rtl/median_frame_ctrl.sv
// median_frame_ctrl: sequences one N*N frame into median_filter and tracks its 3x3/5x5/7x7 result counts
module median_frame_ctrl #(
    parameter int DATA_W     = 8,
    parameter int SIZE_W     = 9,
    parameter int CNT_W      = 18,
    parameter int MIN_SIZE   = 7,
    parameter int CLR_CYCLES = 4,
    parameter int TIMEOUT    = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic [SIZE_W-1:0] cfg_img_size,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [1:0]        err_code_o,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic [SIZE_W-1:0] img_size_o,
    output logic              filter_clr_o,
    input  logic              m_3x3_valid_i,
    input  logic              m_5x5_valid_i,
    input  logic              m_7x7_valid_i
);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam int CLR_W  = $clog2(CLR_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE, ERR} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  pix_q, p_q, e3_q, e5_q, e7_q, c3_q, c5_q, c7_q;
    logic [CNT_W-1:0]  c3_d, c5_d, c7_d, n_in;
    logic [IDLE_W-1:0] idle_q;
    logic [CLR_W-1:0]  clr_q;
    logic [SIZE_W-1:0] size_q;
    logic              err_q;
    logic [1:0]        code_q;
    logic              feed, clr_last, count_en, xfer, last_beat, complete, strobe;

    assign feed          = state_q == FEED;
    assign clr_last      = state_q == CLEAR && clr_q == CLR_W'(CLR_CYCLES - 1);
    assign busy_o        = state_q inside {CLEAR, FEED, DRAIN};
    assign done_o        = state_q == DONE;
    assign err_o         = err_q;
    assign err_code_o    = code_q;
    assign img_size_o    = size_q;
    assign filter_clr_o  = state_q == CLEAR;
    assign s_axis_tready = feed & m_axis_tready;
    assign m_axis_tvalid = feed & s_axis_tvalid;
    assign m_axis_tdata  = feed ? s_axis_tdata : '0;
    assign last_beat     = pix_q == p_q - 1'b1;
    assign m_axis_tlast  = feed & last_beat;
    assign xfer          = feed & s_axis_tvalid & m_axis_tready;
    assign n_in          = CNT_W'(cfg_img_size);
    assign strobe        = m_3x3_valid_i | m_5x5_valid_i | m_7x7_valid_i;
    // results can overlap feeding, so counting opens on the last clear cycle
    assign count_en      = clr_last | feed | (state_q == DRAIN);
    assign c3_d          = (count_en && m_3x3_valid_i && c3_q != e3_q) ? c3_q + 1'b1 : c3_q;
    assign c5_d          = (count_en && m_5x5_valid_i && c5_q != e5_q) ? c5_q + 1'b1 : c5_q;
    assign c7_d          = (count_en && m_7x7_valid_i && c7_q != e7_q) ? c7_q + 1'b1 : c7_q;
    assign complete      = c3_d == e3_q && c5_d == e5_q && c7_d == e7_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pix_q   <= '0;
            p_q     <= '0;
            e3_q    <= '0;
            e5_q    <= '0;
            e7_q    <= '0;
            c3_q    <= '0;
            c5_q    <= '0;
            c7_q    <= '0;
            idle_q  <= '0;
            clr_q   <= '0;
            size_q  <= '0;
            err_q   <= 1'b0;
            code_q  <= 2'd0;
        end else begin
            c3_q <= c3_d;
            c5_q <= c5_d;
            c7_q <= c7_d;
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (cfg_start) begin
                        c3_q   <= '0;
                        c5_q   <= '0;
                        c7_q   <= '0;
                        pix_q  <= '0;
                        idle_q <= '0;
                        clr_q  <= '0;
                        if (cfg_img_size < SIZE_W'(MIN_SIZE)) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                            code_q  <= 2'd1;
                        end else begin
                            state_q <= CLEAR;
                            err_q   <= 1'b0;
                            code_q  <= 2'd0;
                            size_q  <= cfg_img_size;
                            p_q     <= n_in * n_in;
                            e3_q    <= (n_in - CNT_W'(2)) * (n_in - CNT_W'(2));
                            e5_q    <= (n_in - CNT_W'(4)) * (n_in - CNT_W'(4));
                            e7_q    <= (n_in - CNT_W'(6)) * (n_in - CNT_W'(6));
                        end
                    end else if (state_q == DONE) begin
                        state_q <= IDLE;
                    end
                end
                CLEAR: begin
                    clr_q <= clr_q + 1'b1;
                    if (clr_last) state_q <= FEED;
                end
                FEED: begin
                    if (xfer) begin
                        pix_q <= pix_q + 1'b1;
                        if (s_axis_tlast != last_beat) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                            code_q  <= 2'd2;
                        end else if (last_beat) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    idle_q <= strobe ? '0 : idle_q + 1'b1;
                    if (complete) begin
                        state_q <= DONE;
                    end else if (!strobe && idle_q == IDLE_W'(TIMEOUT - 1)) begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                        code_q  <= 2'd3;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_median_frame_ctrl.sv
// tb_median_frame_ctrl: randomized frame stimulus checked against size-derived expectations
module tb_median_frame_ctrl;
    localparam int DATA_W  = 8;
    localparam int SIZE_W  = 9;
    localparam int TIMEOUT = 4096;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_start;
    logic [SIZE_W-1:0] cfg_img_size;
    logic              busy_o, done_o, err_o;
    logic [1:0]        err_code_o;
    logic [DATA_W-1:0] s_axis_tdata, m_axis_tdata;
    logic              s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic              m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [SIZE_W-1:0] img_size_o;
    logic              filter_clr_o;
    logic              m_3x3_valid_i, m_5x5_valid_i, m_7x7_valid_i;

    median_frame_ctrl dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_img_size(cfg_img_size),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .img_size_o(img_size_o),
        .filter_clr_o(filter_clr_o), .m_3x3_valid_i(m_3x3_valid_i), .m_5x5_valid_i(m_5x5_valid_i),
        .m_7x7_valid_i(m_7x7_valid_i)
    );

    always #5 clk = ~clk;

    int passes = 0;
    int total  = 0;
    int fwd, tlast_cnt, tlast_idx, data_bad, tlast_bad, done_cnt, busy_in_done;
    int tready_any, tready_err, err_lag, strobe_cyc, timed_out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame of side n; the filter is modelled only by how many strobes of each kind it emits.
    task automatic run_frame(input int n, input int rdy_mode, input int bad_last, input int drop7,
                             input int extra3, input bit drain_only, input int abort_at, input int poke_at);
        int p, rem3, rem5, rem7, sent, post;
        bit s3, s5, s7, fin;
        logic [DATA_W-1:0] pix;
        p    = n * n;
        rem3 = (n - 2) * (n - 2) + extra3;
        rem5 = (n - 4) * (n - 4);
        rem7 = (n - 6) * (n - 6) - drop7;
        {fwd, tlast_cnt, tlast_idx, data_bad, tlast_bad, done_cnt, busy_in_done} = '0;
        {tready_any, tready_err, timed_out} = '0;
        err_lag = -1;
        strobe_cyc = -1;
        cfg_start = 1'b1;
        cfg_img_size = SIZE_W'(n);
        step();
        cfg_start = 1'b0;
        sent = 0;
        fin = 1'b0;
        post = -1;
        pix = DATA_W'($urandom);
        for (int cyc = 0; cyc < 20000 && post != 0; cyc++) begin
            m_axis_tready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? cyc[0] : 1'($urandom_range(0, 1));
            s_axis_tvalid = sent < p && !fin && (rdy_mode != 2 || $urandom_range(0, 3) != 0);
            s_axis_tdata  = pix;
            s_axis_tlast  = bad_last >= 0 ? sent == bad_last : sent == p - 1;
            cfg_start     = cyc == poke_at;
            cfg_img_size  = cyc == poke_at ? SIZE_W'(5) : SIZE_W'(n);
            s3 = !fin && (drain_only ? sent == p : sent > 0) && rem3 > 0 && $urandom_range(0, 1) == 1;
            s5 = !fin && (drain_only ? sent == p : sent > 0) && rem5 > 0 && $urandom_range(0, 1) == 1;
            s7 = !fin && (drain_only ? sent == p : sent > 0) && rem7 > 0 && $urandom_range(0, 1) == 1;
            m_3x3_valid_i = s3;
            m_5x5_valid_i = s5;
            m_7x7_valid_i = s7;
            @(negedge clk);
            rem3 -= int'(s3);
            rem5 -= int'(s5);
            rem7 -= int'(s7);
            if (s3 || s5 || s7) strobe_cyc = cyc;
            if (m_axis_tvalid && m_axis_tready) begin
                fwd++;
                if (m_axis_tdata !== pix) data_bad++;
                if (m_axis_tlast !== (sent == p - 1)) tlast_bad++;
                if (m_axis_tlast) begin
                    tlast_cnt++;
                    tlast_idx = fwd;
                end
            end
            if (s_axis_tvalid && s_axis_tready) begin
                sent++;
                pix = DATA_W'($urandom);
            end
            tready_any += int'(s_axis_tready);
            if (err_o && s_axis_tready) tready_err++;
            if (done_o) begin
                done_cnt++;
                busy_in_done += int'(busy_o);
            end
            if (!fin && (done_o || err_o)) begin
                fin = 1'b1;
                post = 6;
                // err_o is registered: it shows one cycle after the TIMEOUT-th idle cycle
                if (err_o && strobe_cyc >= 0) err_lag = cyc - strobe_cyc;
            end else if (post > 0) begin
                post--;
            end
            if (!fin && sent == abort_at) begin
                rst = 1'b1;
                post = 0;
            end
            @(posedge clk);
            #1;
        end
        if (post != 0) timed_out = 1;
        m_3x3_valid_i = 1'b0;
        m_5x5_valid_i = 1'b0;
        m_7x7_valid_i = 1'b0;
        s_axis_tvalid = 1'b0;
        cfg_start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        cfg_start = 1'b0;
        cfg_img_size = '0;
        s_axis_tdata = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        m_axis_tready = 1'b0;
        m_3x3_valid_i = 1'b0;
        m_5x5_valid_i = 1'b0;
        m_7x7_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        check("rst_code", err_code_o, 0);
        check("rst_size", img_size_o, 0);
        check("rst_tready", s_axis_tready, 0);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_clr", filter_clr_o, 0);
        check("rst_tlast", m_axis_tlast, 0);
        rst = 1'b0;
        step();

        run_frame(9, 0, -1, 0, 0, 1'b0, -1, -1);
        check("f1_timeout", timed_out, 0);
        check("f1_done", done_cnt, 1);
        check("f1_fwd", fwd, 81);
        check("f1_tlast_cnt", tlast_cnt, 1);
        check("f1_tlast_idx", tlast_idx, 81);
        check("f1_tlast_bad", tlast_bad, 0);
        check("f1_data", data_bad, 0);
        check("f1_err", err_o, 0);
        check("f1_size", img_size_o, 9);
        check("f1_busy_done", busy_in_done, 0);
        check("f1_idle_busy", busy_o, 0);

        run_frame(9, 1, -1, 0, 0, 1'b0, -1, 20);
        check("f2_timeout", timed_out, 0);
        check("f2_done", done_cnt, 1);
        check("f2_fwd", fwd, 81);
        check("f2_tlast_cnt", tlast_cnt, 1);
        check("f2_tlast_idx", tlast_idx, 81);
        check("f2_tlast_bad", tlast_bad, 0);
        check("f2_err", err_o, 0);
        check("f2_size", img_size_o, 9);

        run_frame(5, 0, -1, 0, 0, 1'b0, -1, -1);
        check("f3_err", err_o, 1);
        check("f3_code", err_code_o, 1);
        check("f3_tready", tready_any, 0);
        check("f3_done", done_cnt, 0);
        check("f3_busy", busy_o, 0);

        run_frame(9, 2, -1, 0, 5, 1'b0, -1, -1);
        check("f4_timeout", timed_out, 0);
        check("f4_done", done_cnt, 1);
        check("f4_err", err_o, 0);
        check("f4_code", err_code_o, 0);
        check("f4_fwd", fwd, 81);
        check("f4_data", data_bad, 0);
        check("f4_tlast_bad", tlast_bad, 0);

        run_frame(9, 0, 40, 0, 0, 1'b0, -1, -1);
        check("f5_fwd", fwd, 41);
        check("f5_err", err_o, 1);
        check("f5_code", err_code_o, 2);
        check("f5_tready", tready_err, 0);
        check("f5_data", data_bad, 0);
        check("f5_done", done_cnt, 0);

        run_frame(9, 0, -1, 1, 0, 1'b1, -1, -1);
        check("f6_code", err_code_o, 3);
        check("f6_lag", err_lag, TIMEOUT + 1);
        check("f6_done", done_cnt, 0);
        check("f6_fwd", fwd, 81);

        run_frame(9, 0, -1, 0, 0, 1'b0, 30, -1);
        #1;
        check("f7_fwd", fwd, 30);
        check("f7_busy", busy_o, 0);
        check("f7_err", err_o, 0);
        check("f7_size", img_size_o, 0);
        check("f7_done", done_cnt, 0);
        step();
        rst = 1'b0;
        step();
        run_frame(7, 2, -1, 0, 0, 1'b0, -1, -1);
        check("f8_timeout", timed_out, 0);
        check("f8_done", done_cnt, 1);
        check("f8_fwd", fwd, 49);
        check("f8_tlast_idx", tlast_idx, 49);
        check("f8_err", err_o, 0);
        check("f8_size", img_size_o, 7);

        begin
            int n;
            n = $urandom_range(7, 16);
            run_frame(n, 2, -1, 0, 0, 1'b0, -1, -1);
            check("f9_done", done_cnt, 1);
            check("f9_fwd", fwd, n * n);
            check("f9_tlast_idx", tlast_idx, n * n);
            check("f9_data", data_bad, 0);
            check("f9_size", img_size_o, n);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
